// File: rtl/fpu_pkg.sv
// Shared definitions for the round-robin fpu scheduler: op encodings, data width,
// the flag bundle layout and the scheduler state encoding.
package fpu_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam logic [1:0] FPU_MUL = 2'b10;
  localparam logic [1:0] FPU_DIV = 2'b11;

  // Bit order matches the fpu flag output: [3] overflow .. [0] zero.
  typedef struct packed {
    logic exp_overflow;
    logic exp_underflow;
    logic nan;
    logic zero;
  } fpu_flags_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i   - request vector
//   ptr_i   - index with highest priority this cycle
//   gnt_o   - one-hot grant (zero when no request)
//   idx_o   - index of the granted request
//   valid_o - at least one request present
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           valid_o
);

  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan circularly starting at the pointer; first hit wins.
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_rr_sched.sv
// Round-robin scheduler sharing one combinational fpu among N_REQ requesters.
// Operands of the granted requester are registered onto the fpu inputs and held
// for LAT cycles (multicycle path), then result and flags are captured into a
// response register with valid/ready handshake.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   req_valid/req_ready              - per-requester handshake (ready one-hot or zero)
//   req_opd1/req_opd2/req_op         - packed requester fields, requester i at slice i
//   fpu_opd1/fpu_opd2/fpu_op         - registered fpu inputs
//   fpu_res/fpu_flags                - fpu outputs
//   rsp_valid/rsp_ready              - response handshake
//   rsp_id/rsp_res/rsp_flags         - captured response
//   busy                             - operation in flight or response pending
module fpu_rr_sched
  import fpu_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_opd1,
  input  logic [N_REQ*32-1:0] req_opd2,
  input  logic [N_REQ*2-1:0]  req_op,
  output logic [31:0]         fpu_opd1,
  output logic [31:0]         fpu_opd2,
  output logic [1:0]          fpu_op,
  input  logic [31:0]         fpu_res,
  input  logic [3:0]          fpu_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_res,
  output logic [3:0]          rsp_flags,
  output logic                busy
);

  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;

  sched_state_e    state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0] opd1_q, opd1_d;
  logic [FP_W-1:0] opd2_q, opd2_d;
  logic [1:0]      op_q, op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [FP_W-1:0] rsp_res_q, rsp_res_d;
  fpu_flags_t      rsp_flags_q, rsp_flags_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_valid;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      opd1_q      <= '0;
      opd2_q      <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      opd1_q      <= opd1_d;
      opd2_q      <= opd2_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    opd1_d      = opd1_q;
    opd2_d      = opd2_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          opd1_d  = req_opd1[FP_W*arb_idx +: FP_W];
          opd2_d  = req_opd2[FP_W*arb_idx +: FP_W];
          op_d    = req_op[2*arb_idx +: 2];
          id_d    = arb_idx;
          cnt_d   = CntW'(LAT - 1);
          state_d = StExec;
        end
      end
      StExec: begin
        // fpu inputs have now been stable for LAT cycles when cnt reaches 0.
        if (cnt_q == '0) begin
          rsp_res_d   = fpu_res;
          rsp_flags_d = fpu_flags_t'(fpu_flags);
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle) ? arb_gnt : '0;
    busy      = (state_q != StIdle);
  end

  assign fpu_opd1  = opd1_q;
  assign fpu_opd2  = opd2_q;
  assign fpu_op    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_fpu_rr_sched.sv
// Bench for fpu_rr_sched: table of single operations plus directed sequences for
// contention, backpressure, reset abort and pointer wrap. The fpu is a lookup
// model whose outputs are only meaningful once its inputs have been stable for
// LAT-1 full cycles before the sampling edge.
module tb_fpu_rr_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_opd1;
  logic [N*32-1:0] req_opd2;
  logic [N*2-1:0]  req_op;
  logic [31:0]   fpu_opd1, fpu_opd2, fpu_res;
  logic [1:0]    fpu_op;
  logic [3:0]    fpu_flags;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_res;
  logic [3:0]    rsp_flags;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_rr_sched #(
    .N_REQ (N),
    .LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opd1  (req_opd1),
    .req_opd2  (req_opd2),
    .req_op    (req_op),
    .fpu_opd1  (fpu_opd1),
    .fpu_opd2  (fpu_opd2),
    .fpu_op    (fpu_op),
    .fpu_res   (fpu_res),
    .fpu_flags (fpu_flags),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  // Returns {flags, result} for the operand combinations used here.
  function automatic logic [35:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return {4'b0000, 32'h40400000};
    if (op == 2'b00 && a == 32'h7FC00000 && b == 32'h3F800000) return {4'b0010, 32'h7FC00000};
    if (op == 2'b01 && a == 32'h40000000 && b == 32'h40000000) return {4'b0001, 32'h00000000};
    if (op == 2'b10 && a == 32'h40000000 && b == 32'h3F800000) return {4'b0000, 32'h40000000};
    if (op == 2'b10 && a == 32'h40000000 && b == 32'h40000000) return {4'b0000, 32'h40800000};
    if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return {4'b0000, 32'h40C00000};
    if (op == 2'b10 && a == 32'h40000000 && b == 32'h40800000) return {4'b0000, 32'h41000000};
    if (op == 2'b10 && a == 32'h7F000000 && b == 32'h7F000000) return {4'b1000, 32'h7F800000};
    if (op == 2'b10 && a == 32'h00800000 && b == 32'h00800000) return {4'b0101, 32'h00000000};
    if (op == 2'b11 && a == 32'h40C00000 && b == 32'h40000000) return {4'b0000, 32'h40400000};
    return {a[3:0] ^ b[3:0], a ^ {b[15:0], b[31:16]} ^ {30'd0, op}};
  endfunction

  logic [31:0] prev1, prev2;
  logic [1:0]  prevop;
  int          stable = 0;
  logic [35:0] model_out;

  always @(negedge clk) begin
    if ({fpu_opd1, fpu_opd2, fpu_op} != {prev1, prev2, prevop}) stable <= 0;
    else if (stable < 100) stable <= stable + 1;
    prev1  <= fpu_opd1;
    prev2  <= fpu_opd2;
    prevop <= fpu_op;
  end

  always_comb begin
    model_out = fpu_model(fpu_opd1, fpu_opd2, fpu_op);
    if (stable >= int'(LAT) - 1) {fpu_flags, fpu_res} = model_out;
    else {fpu_flags, fpu_res} = {4'b1111, 32'hDEADBEEF};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    req_opd1[32*i +: 32] = a;
    req_opd2[32*i +: 32] = b;
    req_op[2*i +: 2]     = op;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Caller must be settled (#1 after a negedge); returns at a settled point.
  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready != '0) begin
        g = req_ready;
        return;
      end
      @(negedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout: got no grant, required one within 20 cycles");
  endtask

  task automatic wait_rsp();
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) return;
      @(negedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL rsp_timeout: got no rsp_valid, required one within 20 cycles");
  endtask

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[7];

  task automatic run_single(input vec_t v);
    @(negedge clk);
    set_req(v.who, v.a, v.b, v.op);
    req_valid = 4'b0001 << v.who;
    rsp_ready = 1'b1;
    #1;
    chk("ready_same_cycle", req_ready, 1 << v.who);
    @(posedge clk);
    #1;
    // Requester data only needs to hold during its ready cycle.
    req_valid = '0;
    set_req(v.who, ~v.a, ~v.b, ~v.op);
    chk("fpu_opd1", fpu_opd1, v.a);
    chk("fpu_opd2", fpu_opd2, v.b);
    chk("fpu_op", fpu_op, v.op);
    for (int c = 1; c <= int'(LAT); c++) begin
      @(negedge clk);
      #1;
      chk("rsp_valid_early", rsp_valid, 0);
      chk("busy_exec", busy, 1);
    end
    @(negedge clk);
    #1;
    chk("rsp_valid_on_time", rsp_valid, 1);
    chk("rsp_res", rsp_res, v.res);
    chk("rsp_flags", rsp_flags, v.flags);
    chk("rsp_id", rsp_id, v.who);
    @(negedge clk);
    #1;
    chk("rsp_valid_cleared", rsp_valid, 0);
    chk("busy_idle", busy, 0);
    chk("rsp_res_retained", rsp_res, v.res);
  endtask

  logic [N-1:0] g;
  logic [31:0]  cont_b[4];
  logic [31:0]  cont_r[4];
  int           order[5];

  initial begin
    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000};
    vecs[1] = '{1, 32'h40000000, 32'h40000000, 2'b01, 32'h00000000, 4'b0001};
    vecs[2] = '{2, 32'h7F000000, 32'h7F000000, 2'b10, 32'h7F800000, 4'b1000};
    vecs[3] = '{3, 32'h40C00000, 32'h40000000, 2'b11, 32'h40400000, 4'b0000};
    vecs[4] = '{1, 32'h00800000, 32'h00800000, 2'b10, 32'h00000000, 4'b0101};
    vecs[5] = '{3, 32'h7FC00000, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0010};
    vecs[6] = '{2, 32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 4'b0000};
    cont_b  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    cont_r  = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    order   = '{0, 1, 2, 3, 0};

    req_opd1 = '0;
    req_opd2 = '0;
    req_op   = '0;
    do_reset();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fpu_opd1", fpu_opd1, 0);
    chk("rst_rsp_res", rsp_res, 0);

    for (int i = 0; i < 7; i++) run_single(vecs[i]);

    // Contention: all requesters valid, grants rotate from 0.
    do_reset();
    #1;
    for (int i = 0; i < 4; i++) set_req(i, 32'h40000000, cont_b[i], 2'b10);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("cont_grant", g, 1 << order[k]);
      wait_rsp();
      chk("cont_res", rsp_res, cont_r[order[k]]);
      chk("cont_id", rsp_id, order[k]);
    end
    @(negedge clk);
    req_valid = '0;

    // Backpressure: response held, no new grants until handshake.
    do_reset();
    @(negedge clk);
    set_req(0, 32'h3F800000, 32'h40000000, 2'b00);
    set_req(1, 32'h40C00000, 32'h40000000, 2'b11);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    wait_rsp();
    chk("bp_res_first", rsp_res, 32'h40400000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_res_held", rsp_res, 32'h40400000);
      chk("bp_id_held", rsp_id, 0);
      chk("bp_no_grant", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_valid_at_hs", rsp_valid, 1);
    @(negedge clk);
    #1;
    chk("bp_grant_after_hs", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp();
    chk("bp_res_second", rsp_res, 32'h40400000);
    chk("bp_id_second", rsp_id, 1);

    // Leave the pointer at 3, then abort an operation with reset.
    run_single(vecs[6]);
    @(negedge clk);
    set_req(0, 32'h12345678, 32'h9ABCDEF0, 2'b01);
    req_valid = 4'b0001;
    #1;
    wait_grant(g);
    chk("abort_grant", g, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_fpu_opd1", fpu_opd1, 0);
    chk("abort_fpu_op", fpu_op, 0);
    chk("abort_rsp_res", rsp_res, 0);
    chk("abort_rsp_id", rsp_id, 0);
    chk("abort_rsp_flags", rsp_flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end

    // Pointer back at 0: requester 2 beats 3; then wrap after serving 3.
    set_req(2, 32'h40000000, 32'h40400000, 2'b10);
    set_req(3, 32'h40C00000, 32'h40000000, 2'b11);
    set_req(1, 32'h3F800000, 32'h40000000, 2'b00);
    req_valid = 4'b1100;
    rsp_ready = 1'b1;
    #1;
    wait_grant(g);
    chk("ptr_reset_grant", g, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    wait_rsp();
    chk("ptr_reset_res", rsp_res, 32'h40C00000);
    wait_grant(g);
    chk("grant_3", g, 4'b1000);
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    wait_rsp();
    chk("res_3", rsp_res, 32'h40400000);
    wait_grant(g);
    chk("wrap_grant_1", g, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp();
    chk("wrap_res_1", rsp_res, 32'h40400000);
    chk("wrap_id_1", rsp_id, 1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_rr_sched.md
Name: fpu_rr_sched

Overview:
Shares one combinational fpu instance between N_REQ requesters. Accepts operation requests by round-robin arbitration and registers the operands onto the fpu inputs. Waits a fixed LAT cycles so the fpu path is a multicycle path, then captures the result and flags into a response register with valid/ready backpressure. Sits between the requester ports and the fpu; the fpu itself is instantiated alongside, not inside.

Parameters:
N_REQ, 4, number of requesters (>=2)
LAT, 2, cycles operands are held on the fpu before sampling its outputs (>=1)
ID_W, $clog2(N_REQ), width of requester index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_opd1  in  N_REQ*32  packed operand 1, requester i at [32i+:32]
req_opd2  in  N_REQ*32  packed operand 2
req_op  in  N_REQ*2  packed op: 00 add, 01 sub, 10 mul, 11 div
fpu_opd1  out  32  registered operand 1 to fpu
fpu_opd2  out  32  registered operand 2 to fpu
fpu_op  out  2  registered op to fpu
fpu_res  in  32  fpu result
fpu_flags  in  4  {exp_overflow, exp_underflow, nan, zero} from fpu
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of the requester this response belongs to
rsp_res  out  32  captured result
rsp_flags  out  4  captured flags, same order as fpu_flags
busy  out  1  high in EXEC or RESP

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. Reset clears the state to IDLE, rr pointer to 0, wait counter to 0, and all registers to 0. Outputs at reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_flags=0, fpu_*=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant g = first set req_valid bit scanning circularly from the pointer.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0. req_ready is 0 in every other state.
  - On the edge: fpu_opd1/opd2/op <= requester g's fields, id <= g, cnt <= LAT-1, state -> EXEC.
  - If no req_valid bit is set, stay in IDLE and hold all registers.
- EXEC:
  - fpu_* is stable for LAT cycles.
  - When cnt==0: rsp_res <= fpu_res, rsp_flags <= fpu_flags, rsp_id <= id, rsp_valid <= 1, state -> RESP. Otherwise cnt decrements.
- RESP:
  - rsp_* is held stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, pointer <= (id==N_REQ-1) ? 0 : id+1, state -> IDLE.
- Latency: accept at the edge ending cycle 0. rsp_valid is high from cycle LAT+1. Minimum issue interval is LAT+2 cycles. No overlap of operations.
- rsp_res/flags/id retain their last values after the handshake. fpu_* keeps the last operands while idle.
- Flags are forwarded unmodified. exp_underflow is passed through as the fpu drives it for every op.
- Boundaries:
  - Requester deasserting req_valid before it is granted: no effect.
  - All N_REQ requesters persistently valid: each is served once per N_REQ grants.
  - Pointer wraps from N_REQ-1 to 0.
  - rsp_ready high before rsp_valid: ignored.
  - rst_n asserted mid-EXEC or mid-RESP: the operation is aborted, no response is produced, and state returns to IDLE.
  - LAT=1: EXEC lasts exactly one cycle.
- Requester data must be stable only during its req_ready cycle.

Decomposition:
- Shared package fpu_pkg:
  - op constants FPU_ADD=2'b00, FPU_SUB=2'b01, FPU_MUL=2'b10, FPU_DIV=2'b11
  - FP_W=32
  - packed struct fpu_flags_t {exp_overflow, exp_underflow, nan, zero}
  - state enum sched_state_e
- One sub-module: rr_arbiter (N parameter; req vector + pointer in, one-hot grant + index out), purely combinational.

Test Plan:
- Single add: req 0, opd1=0x3F800000, opd2=0x40000000, op=00, rsp_ready=1. Expect req_ready[0] in the same cycle, rsp_valid in cycle 3 (LAT=2), rsp_res=0x40400000, rsp_id=0, flags=0.
- Contention: all 4 requesters valid continuously, rsp_ready=1. Grant order 0,1,2,3,0. Requester i issues mul of 0x40000000 by (i+1).0, giving rsp_res 0x40000000, 0x40800000, 0x40C00000, 0x41000000.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. rsp_* stays stable, req_ready stays all-0 even with req_valid=4'b1111, busy=1. The next grant occurs the cycle after the handshake.
- Flags: mul 0x7F000000 by 0x7F000000 gives rsp_flags[3]=1. Sub 0x40000000-0x40000000 gives rsp_flags[0]=1 and rsp_res=0x00000000.
- Reset mid-EXEC: pulse rst_n low in cycle 1 after accept. Expect no rsp_valid, all outputs 0, pointer 0. The next request from requester 2 while 0 and 1 are idle is granted first.
- Pointer wrap and priority: after serving requester 3, with requesters 1 and 3 valid, requester 1 is granted first.
